crossbar_rr: RTL and testbench
==============================

Name: crossbar_rr

Overview:
- Registered N×N crossbar switch with valid/ready handshakes on every input and output port.
- Each input presents one word plus a binary destination index.
- Each output has its own round-robin arbiter and a one-entry output register.
- Successor to the purely combinational one-hot-select crossbar: adds flow control, contention resolution, back-pressure and source tagging for use between bus masters and slaves.

Parameters:
- DW, 16, data width per port in bits.
- N, 8, number of input ports and number of output ports (N >= 2).
- AW, $clog2(N), width of destination and source index fields; derived, not overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  N  per-input word valid.
- in_data  input  N*DW  input words, port i at [i*DW +: DW].
- in_dest  input  N*AW  destination output index per input, port i at [i*AW +: AW].
- in_ready  output  N  per-input accept; a beat transfers when in_valid[i] and in_ready[i] are both high.
- out_valid  output  N  per-output word valid (registered).
- out_data  output  N*DW  output words, port j at [j*DW +: DW] (registered).
- out_src  output  N*AW  index of the input that supplied out_data for port j (registered).
- out_ready  input  N  per-output downstream accept.

Behaviour:
- Reset, synchronous, rst=1 at a clk edge:
  - out_valid=0, out_data=0, out_src=0.
  - All round-robin pointers ptr[j]=0.
  - in_ready is 0 while rst is high.
  - Reset mid-transfer discards any held output words without handshake.
- Request: input i requests output j when in_valid[i]=1 and in_dest[i]==j.
- Invalid destination: in_dest >= N (possible only for non-power-of-2 N) requests nothing; in_ready[i] stays 0 and the input stalls.
- Output slot free: output j can load when out_valid[j]=0 OR out_ready[j]=1 (pass-through of a draining slot, full throughput, no bubble).
- Arbitration per output j, combinational:
  - Among requesting inputs, grant the first index found searching ptr[j], ptr[j]+1, ..., wrapping modulo N.
  - Only one grant per output.
  - An input requests exactly one output, so it receives at most one grant.
- in_ready[i]=1 iff input i is granted by its destination output, that output can load, and rst=0.
- On a grant at a clk edge:
  - out_data[j] <= in_data[winner]; out_src[j] <= winner; out_valid[j] <= 1.
  - ptr[j] <= (winner+1) mod N.
- No grant to output j: if out_ready[j]=1 then out_valid[j] <= 0. out_data and out_src hold their values; they are don't-care when out_valid=0.
- Pointer hold: ptr[j] changes only on a grant for output j.
- Stall: out_valid[j]=1 and out_ready[j]=0 → out_data[j], out_src[j] and ptr[j] hold. All inputs targeting j see in_ready=0.
- Latency: a word accepted at edge k appears on out_data at edge k, visible in cycle k+1. One-cycle latency and one word per output per cycle sustained.
- Independence: outputs operate in parallel. N inputs with a permutation of destinations all transfer in the same cycle.
- Ordering: words from a single input to a single output are delivered in order.
- Fairness: with continuous contention, each requesting input gets one grant per at most N grants of that output.
- Combinational paths:
  - in_ready depends combinationally on in_valid, in_dest, out_ready and registered state.
  - No combinational path from in_data to any output.

Test Plan (N=4, DW=8 unless noted):
- Reset: assert rst 2 cycles with in_valid=4'hF → out_valid=0, out_data=0, out_src=0, in_ready=0 throughout. After deassert, first grants start from index 0.
- Permutation: in_data={8'h44,8'h33,8'h22,8'h11}, in_dest={0,1,2,3} (input 0→3, 1→2, 2→1, 3→0), out_ready=4'hF → in_ready=4'hF. Next cycle out_data[3]=8'h11 src 0, out_data[2]=8'h22 src 1, out_data[1]=8'h33 src 2, out_data[0]=8'h44 src 3.
- Contention round-robin: all 4 inputs hold in_valid with dest 2, out_ready[2]=1 → grants in order 0,1,2,3,0 on consecutive cycles; out_src[2] sequence 0,1,2,3,0; one in_ready bit high per cycle.
- Back-pressure: output 1 holds word 8'hA5 with out_ready[1]=0 for 3 cycles while input 2 requests dest 1 → in_ready[2]=0, out_data[1] stays 8'hA5. When out_ready[1]=1, input 2 is accepted that same cycle and its word appears next cycle with no bubble.
- Pointer wrap and skip: ptr[0]=3, only inputs 1 and 2 request dest 0 → input 1 is granted and ptr[0] becomes 2. Next cycle input 2 is granted and ptr[0] becomes 3.
- Invalid destination (N=3, AW=2): input 0 with in_dest=3 → in_ready[0]=0 indefinitely, no out_valid asserted, other inputs unaffected.

Source files
------------

// File: rtl/crossbar_rr_if.sv
// crossbar_rr_if: valid/ready bundle for every input and output port of crossbar_rr
interface crossbar_rr_if #(
  parameter int N = 8,
  parameter int DW = 16
);
  localparam int AW = $clog2(N);
  logic [N-1:0] in_valid, in_ready, out_valid, out_ready;
  logic [N*DW-1:0] in_data, out_data;
  logic [N*AW-1:0] in_dest, out_src;
  modport master(output in_valid, in_data, in_dest, out_ready, input in_ready, out_valid, out_data, out_src);
  modport slave(input in_valid, in_data, in_dest, out_ready, output in_ready, out_valid, out_data, out_src);
endinterface

// File: rtl/crossbar_rr.sv
// crossbar_rr: registered NxN crossbar with per-output round-robin arbitration and valid/ready flow control
module crossbar_rr #(
  parameter int DW = 16,
  parameter int N = 8
) (
  input logic clk,
  input logic rst,
  crossbar_rr_if.slave bus
);
  localparam int AW = $clog2(N);
  logic [N-1:0][DW-1:0] data, od;
  logic [N-1:0][AW-1:0] dest, win, os, ptr;
  logic [N-1:0] gnt, load, ov, rdy;
  logic [AW-1:0] idx;
  assign data = bus.in_data;
  assign dest = bus.in_dest;
  assign bus.in_ready = rdy;
  assign bus.out_valid = ov;
  assign bus.out_data = od;
  assign bus.out_src = os;
  assign load = ~ov | bus.out_ready;
  always_comb begin
    gnt = '0;
    win = '0;
    rdy = '0;
    idx = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = AW'((int'(ptr[j]) + k) % N);
        if (bus.in_valid[idx] && dest[idx] == AW'(j)) begin
          gnt[j] = 1'b1;
          win[j] = idx;
        end
      end
      if (gnt[j] && load[j] && !rst) rdy[win[j]] = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      ov <= '0;
      od <= '0;
      os <= '0;
      ptr <= '0;
    end else
      for (int j = 0; j < N; j++)
        if (load[j]) begin
          ov[j] <= gnt[j];
          if (gnt[j]) begin
            od[j] <= data[win[j]];
            os[j] <= win[j];
            ptr[j] <= AW'((int'(win[j]) + 1) % N);
          end
        end
endmodule

// File: tb/tb_crossbar_rr.sv
// tb_crossbar_rr: table-driven vectors with an output scoreboard for crossbar_rr (N=4), plus an N=3 invalid-destination case
module tb_crossbar_rr;
  localparam int N = 4;
  localparam int DW = 8;
  localparam logic [31:0] D0 = 32'h44332211;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic prev_rst = 1'b1;
  always #5 clk = ~clk;
  crossbar_rr_if #(.N(N), .DW(DW)) b4();
  crossbar_rr_if #(.N(3), .DW(DW)) b3();
  crossbar_rr #(.DW(DW), .N(N)) dut(.clk(clk), .rst(rst), .bus(b4));
  crossbar_rr #(.DW(DW), .N(3)) dut3(.clk(clk), .rst(rst), .bus(b3));
  typedef struct {
    logic rs;
    logic [3:0] iv;
    logic [7:0] dest;
    logic [31:0] data;
    logic [3:0] ordy;
    logic [3:0] eiry;
    logic [3:0] eov;
  } vec_t;
  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;
  vec_t tv[$];
  exp_t sb[N][$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t v);
    exp_t e;
    rst = v.rs;
    b4.in_valid = v.iv;
    b4.in_dest = v.dest;
    b4.in_data = v.data;
    b4.out_ready = v.ordy;
    #1;
    chk("in_ready", b4.in_ready, v.eiry);
    chk("out_valid", b4.out_valid, v.eov);
    if (prev_rst) begin
      chk("rst_out_data", b4.out_data, 0);
      chk("rst_out_src", b4.out_src, 0);
    end
    for (int j = 0; j < N; j++)
      if (b4.out_valid[j] && b4.out_ready[j]) begin
        if (sb[j].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: output %0d produced %0h with nothing expected", j, b4.out_data[j*8 +: 8]);
        end else begin
          e = sb[j].pop_front();
          chk($sformatf("out_data[%0d]", j), b4.out_data[j*8 +: 8], e.d);
          chk($sformatf("out_src[%0d]", j), b4.out_src[j*2 +: 2], e.s);
        end
      end
    for (int i = 0; i < N; i++)
      if (v.iv[i] && b4.in_ready[i]) sb[v.dest[i*2 +: 2]].push_back('{d: v.data[i*8 +: 8], s: 2'(i)});
    @(posedge clk);
    prev_rst = v.rs;
    if (v.rs) for (int j = 0; j < N; j++) sb[j].delete();
    @(negedge clk);
  endtask
  initial begin
    int left;
    b4.in_valid = '0;
    b4.in_dest = '0;
    b4.in_data = '0;
    b4.out_ready = '1;
    b3.in_valid = '0;
    b3.in_dest = '0;
    b3.in_data = '0;
    b3.out_ready = '1;
    tv.push_back('{1'b1, 4'hF, 8'h00, D0, 4'hF, 4'h0, 4'h0});
    tv.push_back('{1'b1, 4'hF, 8'h00, D0, 4'hF, 4'h0, 4'h0});
    tv.push_back('{1'b0, 4'hF, 8'hAA, D0, 4'hF, 4'h1, 4'h0});
    tv.push_back('{1'b0, 4'hF, 8'hAA, D0, 4'hF, 4'h2, 4'h4});
    tv.push_back('{1'b0, 4'hF, 8'hAA, D0, 4'hF, 4'h4, 4'h4});
    tv.push_back('{1'b0, 4'hF, 8'hAA, D0, 4'hF, 4'h8, 4'h4});
    tv.push_back('{1'b0, 4'hF, 8'hAA, D0, 4'hF, 4'h1, 4'h4});
    tv.push_back('{1'b0, 4'hF, 8'h1B, D0, 4'hF, 4'hF, 4'h4});
    tv.push_back('{1'b0, 4'h0, 8'h00, D0, 4'hF, 4'h0, 4'hF});
    tv.push_back('{1'b0, 4'h1, 8'h01, 32'h443322A5, 4'hF, 4'h1, 4'h0});
    tv.push_back('{1'b0, 4'h4, 8'h10, 32'h445A22A5, 4'hD, 4'h0, 4'h2});
    tv.push_back('{1'b0, 4'h4, 8'h10, 32'h445A22A5, 4'hD, 4'h0, 4'h2});
    tv.push_back('{1'b0, 4'h4, 8'h10, 32'h445A22A5, 4'hD, 4'h0, 4'h2});
    tv.push_back('{1'b0, 4'h4, 8'h10, 32'h445A22A5, 4'hF, 4'h4, 4'h2});
    tv.push_back('{1'b0, 4'h0, 8'h00, D0, 4'hF, 4'h0, 4'h2});
    tv.push_back('{1'b0, 4'h4, 8'h00, D0, 4'hF, 4'h4, 4'h0});
    tv.push_back('{1'b0, 4'h6, 8'h00, D0, 4'hF, 4'h2, 4'h1});
    tv.push_back('{1'b0, 4'h6, 8'h00, D0, 4'hF, 4'h4, 4'h1});
    tv.push_back('{1'b0, 4'h0, 8'h00, D0, 4'hF, 4'h0, 4'h1});
    tv.push_back('{1'b0, 4'h6, 8'h00, D0, 4'hF, 4'h2, 4'h0});
    tv.push_back('{1'b0, 4'h0, 8'h00, D0, 4'hF, 4'h0, 4'h1});
    tv.push_back('{1'b0, 4'h1, 8'h03, D0, 4'h7, 4'h1, 4'h0});
    tv.push_back('{1'b1, 4'hF, 8'h00, D0, 4'h0, 4'h0, 4'h8});
    tv.push_back('{1'b0, 4'h0, 8'h00, D0, 4'hF, 4'h0, 4'h0});
    tv.push_back('{1'b0, 4'hF, 8'hAA, D0, 4'hF, 4'h1, 4'h0});
    tv.push_back('{1'b0, 4'h0, 8'h00, D0, 4'hF, 4'h0, 4'h4});
    @(posedge clk);
    @(negedge clk);
    foreach (tv[r]) step(tv[r]);
    left = 0;
    for (int j = 0; j < N; j++) left += sb[j].size();
    chk("sb_drained", 64'(left), 0);
    b3.in_valid = 3'b011;
    b3.in_dest = 6'b00_10_11;
    b3.in_data = {8'h00, 8'h77, 8'h99};
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("n3_in_ready", b3.in_ready, 3'b010);
      chk("n3_out_valid", b3.out_valid, c == 0 ? 3'b000 : 3'b100);
      if (c > 0) begin
        chk("n3_out_data", b3.out_data[23:16], 8'h77);
        chk("n3_out_src", b3.out_src[5:4], 2'd1);
      end
      @(posedge clk);
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
